// File: rtl/mtm_alu_serializer.sv
// Serial output stage of the ALU: one accepted result becomes 4 data frames + 1 control
// frame (or 1 control frame on error). Optional build macro: MTM_ALU_SER_CRC_EN.
module mtm_alu_serializer #(
    parameter int IFG = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] C_in,
    input  logic [7:0]  CTL_in,
    input  logic        valid_in,
    output logic        ready_out,
    output logic        sout,
    output logic [2:0]  o_dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_TYPE, S_DATA, S_STOP, S_GAP
    } state_t;

    localparam bit         HAS_GAP  = (IFG > 0);
    localparam logic [2:0] GAP_LAST = 3'(IFG - 1);

    state_t      r_state;
    state_t      w_state_nxt;
    logic [2:0]  r_frame_cnt, w_frame_nxt;
    logic [2:0]  r_bit_cnt, w_bit_nxt;
    logic [2:0]  r_gap_cnt, w_gap_nxt;
    logic [31:0] r_c;
    logic [7:0]  r_ctl;
    logic        r_sout;

    logic        w_err;
    logic        w_last_frame;
    logic        w_frame_end;
    logic        w_ready;
    logic        w_accept;
    logic [7:0]  w_ctl_tx;
    logic [7:0]  w_payload;
    logic        w_bit;

    // Handshake: a transaction is taken on a rising edge where valid_in and ready_out are
    // both high; ready_out is high in IDLE and while the last bit of a transaction is being
    // launched, so a waiting request chains on with no idle bit in between.
    assign w_err        = r_ctl[7];
    assign w_last_frame = w_err || (r_frame_cnt == 3'd4);
    assign w_frame_end  = (r_state == S_STOP && !HAS_GAP) ||
                          (r_state == S_GAP && r_gap_cnt == GAP_LAST);
    assign w_ready      = (r_state == S_IDLE) || (w_frame_end && w_last_frame);
    assign w_accept     = valid_in && w_ready;

`ifdef MTM_ALU_SER_CRC_EN
    function automatic logic [2:0] crc3(input logic [36:0] d);
        logic [2:0] c;
        logic       fb;
        c = 3'b000;
        for (int i = 36; i >= 0; i--) begin
            fb = c[2] ^ d[i];
            c  = {c[1], c[0] ^ fb, fb};
        end
        return c;
    endfunction

    assign w_ctl_tx = w_err ? r_ctl : {r_ctl[7:3], crc3({r_c, 1'b0, r_ctl[6:3]})};
`else
    assign w_ctl_tx = r_ctl;
`endif

    always_comb begin
        w_payload = w_ctl_tx;
        if (!w_err) begin
            case (r_frame_cnt)
                3'd0:    w_payload = r_c[31:24];
                3'd1:    w_payload = r_c[23:16];
                3'd2:    w_payload = r_c[15:8];
                3'd3:    w_payload = r_c[7:0];
                default: w_payload = w_ctl_tx;
            endcase
        end
    end

    // The bit chosen here appears on sout one clock later through r_sout.
    always_comb begin
        case (r_state)
            S_START: w_bit = 1'b0;
            S_TYPE:  w_bit = w_last_frame;
            S_DATA:  w_bit = w_payload[3'd7 - r_bit_cnt];
            default: w_bit = 1'b1;
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        w_frame_nxt = r_frame_cnt;
        w_bit_nxt   = r_bit_cnt;
        w_gap_nxt   = r_gap_cnt;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = S_START;
                    w_frame_nxt = 3'd0;
                end
            end
            S_START: w_state_nxt = S_TYPE;
            S_TYPE: begin
                w_state_nxt = S_DATA;
                w_bit_nxt   = 3'd0;
            end
            S_DATA: begin
                w_bit_nxt = r_bit_cnt + 3'd1;
                if (r_bit_cnt == 3'd7) w_state_nxt = S_STOP;
            end
            S_STOP: begin
                if (HAS_GAP) begin
                    w_state_nxt = S_GAP;
                    w_gap_nxt   = 3'd0;
                end
            end
            S_GAP:   w_gap_nxt = r_gap_cnt + 3'd1;
            default: w_state_nxt = S_IDLE;
        endcase
        if (w_frame_end) begin
            if (!w_last_frame) begin
                w_state_nxt = S_START;
                w_frame_nxt = r_frame_cnt + 3'd1;
            end else if (w_accept) begin
                w_state_nxt = S_START;
                w_frame_nxt = 3'd0;
            end else begin
                w_state_nxt = S_IDLE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_frame_cnt <= 3'd0;
            r_bit_cnt   <= 3'd0;
            r_gap_cnt   <= 3'd0;
            r_c         <= 32'd0;
            r_ctl       <= 8'd0;
            r_sout      <= 1'b1;
        end else begin
            r_state     <= w_state_nxt;
            r_frame_cnt <= w_frame_nxt;
            r_bit_cnt   <= w_bit_nxt;
            r_gap_cnt   <= w_gap_nxt;
            r_sout      <= w_bit;
            if (w_accept) begin
                r_c   <= C_in;
                r_ctl <= CTL_in;
            end
        end
    end

    assign ready_out   = w_ready;
    assign sout        = r_sout;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_mtm_alu_serializer.sv
// Bench for mtm_alu_serializer: expected bit streams are built frame by frame from the
// frame format; two instances cover IFG = 0 and IFG = 2.
module tb_mtm_alu_serializer;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] c_in;
    logic [7:0]  ctl_in;
    logic        valid_in;
    logic        sout0, ready0, sout2, ready2;
    logic [2:0]  dbg0, dbg2;

    logic [0:0]  exp_q[$];
    logic [0:0]  rdy_q[$];
    int          vectors = 0;
    int          miscompares = 0;

    always #5 clk = ~clk;

    mtm_alu_serializer #(.IFG(0)) dut0 (
        .clk(clk), .rst(rst), .C_in(c_in), .CTL_in(ctl_in), .valid_in(valid_in),
        .ready_out(ready0), .sout(sout0), .o_dbg_state(dbg0)
    );

    mtm_alu_serializer #(.IFG(2)) dut2 (
        .clk(clk), .rst(rst), .C_in(c_in), .CTL_in(ctl_in), .valid_in(valid_in),
        .ready_out(ready2), .sout(sout2), .o_dbg_state(dbg2)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic sout_of(input logic sel);
        return sel ? sout2 : sout0;
    endfunction

    function automatic logic ready_of(input logic sel);
        return sel ? ready2 : ready0;
    endfunction

`ifdef MTM_ALU_SER_CRC_EN
    // Remainder of M(x)*x^3 divided by x^3+x+1, by polynomial long division.
    function automatic logic [2:0] crc3_ref(input logic [31:0] c, input logic [3:0] hi);
        logic [39:0] v;
        v = {c, 1'b0, hi, 3'b000};
        for (int i = 39; i >= 3; i--)
            if (v[i]) v[i -: 4] = v[i -: 4] ^ 4'b1011;
        return v[2:0];
    endfunction
`endif

    function automatic logic [7:0] ctl_expected(input logic [31:0] c, input logic [7:0] ctl);
`ifdef MTM_ALU_SER_CRC_EN
        if (!ctl[7]) return {ctl[7:3], crc3_ref(c, ctl[6:3])};
`endif
        return ctl;
    endfunction

    task automatic push_frame(input logic typ, input logic [7:0] pay, input int ifg);
        exp_q.push_back(1'b0);
        exp_q.push_back(typ);
        for (int i = 7; i >= 0; i--) exp_q.push_back(pay[i]);
        exp_q.push_back(1'b1);
        for (int i = 0; i < ifg; i++) exp_q.push_back(1'b1);
    endtask

    // Appends one transaction; ready is expected while its final bit is being launched,
    // i.e. in the sample slot just before that bit shows up on sout.
    task automatic push_txn(input logic [31:0] c, input logic [7:0] ctl, input int ifg);
        logic [7:0] ce;
        ce = ctl_expected(c, ctl);
        if (ctl[7]) begin
            push_frame(1'b1, ce, ifg);
        end else begin
            for (int f = 0; f < 4; f++) push_frame(1'b0, c[31 - 8 * f -: 8], ifg);
            push_frame(1'b1, ce, ifg);
        end
        while (rdy_q.size() < exp_q.size()) rdy_q.push_back(1'b0);
        rdy_q[rdy_q.size() - 2] = 1'b1;
    endtask

    task automatic begin_txn(input logic sel, input logic [31:0] c, input logic [7:0] ctl,
                             input int ifg, input string tag);
        check({tag, "_rdy_pre"}, ready_of(sel), 1);
        push_txn(c, ctl, ifg);
        valid_in = 1'b1;
        c_in     = c;
        ctl_in   = ctl;
    endtask

    task automatic run_stream(input logic sel, input int drop_at, input logic [31:0] c2,
                              input logic [7:0] ctl2, input int pulse_at, input int rst_at,
                              input string tag);
        int total;
        @(negedge clk);
        if (drop_at >= 0) begin
            c_in   = c2;
            ctl_in = ctl2;
        end else begin
            valid_in = 1'b0;
            c_in     = $urandom;
            ctl_in   = 8'($urandom);
        end
        check({tag, "_rdy_busy"}, ready_of(sel), 0);
        total = exp_q.size();
        for (int k = 0; k < total; k++) begin
            @(negedge clk);
            check($sformatf("%s_sout[%0d]", tag, k), sout_of(sel), exp_q[k]);
            check($sformatf("%s_rdy[%0d]", tag, k), ready_of(sel), rdy_q[k] || (k == total - 1));
            if (rst_at >= 0 && k == rst_at) begin
                rst = 1'b0;
                #1;
                check({tag, "_rst_sout"}, sout_of(sel), 1);
                check({tag, "_rst_rdy"}, ready_of(sel), 1);
                break;
            end
            if (pulse_at >= 0 && k == pulse_at) begin
                valid_in = 1'b1;
                c_in     = 32'hAAAAAAAA;
                ctl_in   = 8'h00;
            end else if (pulse_at >= 0 && k == pulse_at + 1) begin
                valid_in = 1'b0;
                c_in     = $urandom;
            end
            if (drop_at >= 0 && k == drop_at) begin
                valid_in = 1'b0;
                c_in     = $urandom;
                ctl_in   = 8'($urandom);
            end
        end
        exp_q.delete();
        rdy_q.delete();
    endtask

    task automatic idle_check(input logic sel, input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            check({tag, "_idle_sout"}, sout_of(sel), 1);
            check({tag, "_idle_rdy"}, ready_of(sel), 1);
        end
    endtask

    initial begin
        logic [31:0] c1, c2;
        logic [7:0]  t1, t2;
        int          n1;

        // Reset held with a request pending: line idle, ready high.
        rst      = 1'b0;
        valid_in = 1'b1;
        c_in     = $urandom;
        ctl_in   = 8'h05;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("rst_sout0", sout0, 1);
            check("rst_rdy0", ready0, 1);
            check("rst_sout2", sout2, 1);
            check("rst_rdy2", ready2, 1);
        end
        rst      = 1'b1;
        valid_in = 1'b0;
        idle_check(0, 4, "post_rst");

        begin_txn(0, 32'h12345678, 8'h05, 0, "normal");
        run_stream(0, -1, 32'h0, 8'h0, -1, -1, "normal");
        idle_check(0, 2, "normal");

        begin_txn(0, 32'hFFFFFFFF, 8'hC9, 0, "error");
        run_stream(0, -1, 32'h0, 8'h0, -1, -1, "error");
        idle_check(0, 2, "error");

        begin_txn(0, $urandom, 8'h1A, 0, "busy");
        run_stream(0, -1, 32'h0, 8'h0, 15, -1, "busy");
        idle_check(0, 2, "busy");

        begin_txn(0, $urandom, 8'h3C, 0, "rst_mid");
        run_stream(0, -1, 32'h0, 8'h0, -1, 22, "rst_mid");
        for (int i = 0; i < 3; i++) begin
            valid_in = 1'b1;
            c_in     = $urandom;
            @(negedge clk);
            check("rst_mid_hold_sout", sout0, 1);
            check("rst_mid_hold_rdy", ready0, 1);
        end
        rst      = 1'b1;
        valid_in = 1'b0;
        idle_check(0, 4, "rst_mid_rel");
        begin_txn(0, 32'h00000001, 8'h00, 0, "after_rst");
        run_stream(0, -1, 32'h0, 8'h0, -1, -1, "after_rst");
        idle_check(0, 1, "after_rst");

        for (int i = 0; i < 6; i++) begin
            c1 = $urandom;
            t1 = 8'($urandom);
            t1[7] = i[0];
            begin_txn(0, c1, t1, 0, $sformatf("rand%0d", i));
            run_stream(0, -1, 32'h0, 8'h0, -1, -1, $sformatf("rand%0d", i));
            idle_check(0, 1, $sformatf("rand%0d", i));
        end

        c1 = $urandom; t1 = 8'($urandom); t1[7] = 1'b0;
        c2 = $urandom; t2 = 8'($urandom); t2[7] = 1'b1;
        begin_txn(0, c1, t1, 0, "b2b_ifg0");
        n1 = exp_q.size();
        push_txn(c2, t2, 0);
        run_stream(0, n1 - 1, c2, t2, -1, -1, "b2b_ifg0");
        idle_check(0, 2, "b2b_ifg0");

        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        idle_check(1, 2, "ifg2_pre");
        c1 = $urandom; t1 = 8'($urandom); t1[7] = 1'b0;
        c2 = $urandom; t2 = 8'($urandom); t2[7] = 1'b0;
        begin_txn(1, c1, t1, 2, "b2b_ifg2");
        n1 = exp_q.size();
        push_txn(c2, t2, 2);
        run_stream(1, n1 - 1, c2, t2, -1, -1, "b2b_ifg2");
        idle_check(1, 2, "b2b_ifg2");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mtm_alu_serializer.md
# mtm_alu_serializer

Output stage of the ALU datapath, directly downstream of the ALU core. It accepts one result transaction per handshake: a 32-bit result `C_in` plus an 8-bit control byte `CTL_in`. It emits the transaction on the single-wire serial output `sout`, using the same frame format the input deserializer decodes. A normal result is sent as four data frames followed by one control frame; an error response is sent as a single control frame.

## Interface
- `IFG`, default 0: number of idle-high bits inserted after every frame, range 0..7.
- `clk`  input  1  system clock; all state changes on the rising edge.
- `rst`  input  1  reset, asynchronous, active-low.
- `C_in`  input  32  ALU result; sampled only on accept.
- `CTL_in`  input  8  control byte; bit 7 = 1 marks an error frame; sampled only on accept.
- `valid_in`  input  1  transaction request.
- `ready_out`  output  1  serializer can accept a transaction this cycle.
- `sout`  output  1  serial line; registered; idle level is 1.

## Operation
- **Frame format (11 bits, one bit per clk):** start 0, then type bit, then 8 payload bits MSB first, then stop 1.
  - Type bit: 0 = data frame, 1 = control frame.
- **Accept:** accept occurs on a rising edge where `valid_in` = 1 and `ready_out` = 1. On accept, `C_in` and `CTL_in` are latched into internal registers.
- **Normal transaction (latched CTL[7] = 0):**
  - Data frames carry C[31:24], C[23:16], C[15:8], C[7:0], in that order.
  - Then one control frame carrying CTL.
- **Error transaction (latched CTL[7] = 1):** one control frame carrying CTL only. C is ignored.
- **Idle gap:** after every frame, `IFG` idle bits with `sout` = 1.
- **FSM states:**
  - IDLE: `sout` = 1.
  - START.
  - TYPE.
  - DATA: 8 bits, counted by a 3-bit counter.
  - STOP.
  - GAP: skipped when `IFG` = 0.
- **FSM transitions:**
  - IDLE to START on accept.
  - STOP (or GAP, when `IFG` > 0) to START for the next frame.
  - From the final STOP/GAP of the transaction: to START if a new transaction is accepted that cycle, otherwise to IDLE.
- **Frame counter:** 3 bits, 0..4. It selects the payload byte; the type bit is 1 only when the counter is 4 or the transaction is an error transaction.
- **`ready_out`:** high in IDLE and during the final bit of a transaction (last STOP when `IFG` = 0, last GAP bit otherwise). Low at all other times.
- **`valid_in` while `ready_out` = 0:** ignored. No queuing; the current stream is unaffected.

## Timing
- **Reset:** `rst` low forces, immediately and asynchronously: `sout` = 1, `ready_out` = 1, FSM = IDLE, counters = 0.
- **Latency:** accept at edge E, start bit on `sout` from edge E+1.
- **Normal transaction:** occupies 5·(11+IFG) bit cycles. With `IFG` = 0 the final stop bit is driven from E+55 to E+56.
- **Error transaction:** occupies 11+IFG bit cycles.
- **Back-to-back:** an accept during the final bit makes the next start bit follow it with no extra idle cycle.
- **Reset mid-frame:** the frame is aborted with no completion. `sout` returns to 1 at once. After reset release, the block waits in IDLE for a new accept.
- **Input stability:** `C_in` and `CTL_in` may change freely after accept.

## Configuration
- **`MTM_ALU_SER_CRC_EN` defined:**
  - For normal transactions, the serializer computes CRC-3 itself and overwrites CTL[2:0] with it.
  - Polynomial x³+x+1, init 000.
  - Computed over the 37-bit vector {C[31:0], 1'b0, CTL[6:3]}, MSB first.
  - Error transactions pass CTL unchanged.
- **Not defined:** CTL is transmitted verbatim as latched.

## Test plan
- **Reset:** hold `rst` = 0 with `valid_in` = 1 → `sout` = 1 and `ready_out` = 1 throughout; no frame after release until a new valid.
- **Normal transaction:** `C_in` = 0x12345678, `CTL_in` = 0x05, `IFG` = 0 → `sout` carries 0_0_00010010_1, 0_0_00110100_1, 0_0_01010110_1, 0_0_01111000_1, 0_1_00000101_1 (55 cycles); `ready_out` is low from E+1, high during the last stop bit.
  - With `MTM_ALU_SER_CRC_EN` defined: CTL[2:0] must match a bit-serial reference model.
- **Error transaction:** `CTL_in` = 0xC9, `C_in` = 0xFFFFFFFF → a single frame 0_1_11001001_1, then idle, with `ready_out` = 1 after 11 cycles.
- **Request while busy:** `valid_in` pulsed with `C_in` = 0xAAAAAAAA during frame 2 → pulse ignored; the original 55-bit stream is unchanged.
- **Reset mid-transaction:** `rst` = 0 during frame 3 → `sout` = 1 the same cycle. After release, `C_in` = 0x00000001, `CTL_in` = 0x00 produces a clean 55-bit stream.
- **Back-to-back and gap:** two transactions with `valid_in` held high.
  - `IFG` = 0: second start bit immediately follows the first transaction's last stop bit.
  - `IFG` = 2: exactly two 1-bits after every stop bit, and 65 cycles per normal transaction.
